// File: rtl/sha3_padder_param_if.sv
// Message-word and block handshake bundle between the user, the padder and the permutation.
// The master drives message words and f_ack; the slave (padder) returns the assembled block.
interface sha3_padder_param_if #(
    parameter int IN_W      = 32,
    parameter int RATE_BITS = 1088,
    parameter int BYTE_W    = $clog2(IN_W / 8)
);
    logic [IN_W-1:0]      in;
    logic                 in_ready;
    logic                 is_last;
    logic [BYTE_W-1:0]    byte_num;
    logic                 buffer_full;
    logic [RATE_BITS-1:0] out;
    logic                 out_ready;
    logic                 out_last;
    logic                 f_ack;

    modport master (
        output in, in_ready, is_last, byte_num, f_ack,
        input  buffer_full, out, out_ready, out_last
    );

    modport slave (
        input  in, in_ready, is_last, byte_num, f_ack,
        output buffer_full, out, out_ready, out_last
    );
endinterface

// File: rtl/sha3_padder_param.sv
// SHA-3 block assembler with pad10*1; domain byte 0x06, or 0x01 when SHA3_PADDER_LEGACY_KECCAK_EN is defined.
// Block is presented 1 cycle after its completing word; input stalls via buffer_full until f_ack.
module sha3_padder_param #(
    parameter int IN_W      = 32,
    parameter int RATE_BITS = 1088,
    parameter int BYTE_W    = $clog2(IN_W / 8)
) (
    input  logic                clk,
    input  logic                reset,
    sha3_padder_param_if.slave  bus
);

    localparam int WORDS = RATE_BITS / IN_W;
    localparam int BYTES = IN_W / 8;
    localparam int IDX_W = $clog2(WORDS);

`ifdef SHA3_PADDER_LEGACY_KECCAK_EN
    localparam logic [7:0] DOM = 8'h01;
`else
    localparam logic [7:0] DOM = 8'h06;
`endif

    typedef enum logic {ABSORB, FULL} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [RATE_BITS-1:0] blk_q, blk_d;
    logic                 last_q, last_d;

    logic [BYTE_W-1:0]    nbytes;
    logic [IN_W-1:0]      pad_word;
    logic [IN_W-1:0]      word;

    assign nbytes = bus.byte_num;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        blk_d    = blk_q;
        last_d   = last_q;
        pad_word = '0;
        word     = bus.in;

        // Final word: keep the valid leading bytes, then the domain byte, then zeros.
        for (int b = 0; b < BYTES; b++) begin
            if (b < int'(nbytes)) begin
                pad_word[IN_W-1-8*b -: 8] = bus.in[IN_W-1-8*b -: 8];
            end else if (b == int'(nbytes)) begin
                pad_word[IN_W-1-8*b -: 8] = DOM;
            end
        end

        case (state_q)
            ABSORB: begin
                if (bus.in_ready) begin
                    word = bus.is_last ? pad_word : bus.in;
                    for (int k = 0; k < WORDS; k++) begin
                        if (k == int'(idx_q)) begin
                            blk_d[RATE_BITS-1-k*IN_W -: IN_W] = word;
                        end else if (bus.is_last && (k > int'(idx_q))) begin
                            blk_d[RATE_BITS-1-k*IN_W -: IN_W] = '0;
                        end
                    end
                    if (bus.is_last) begin
                        // The trailing 1 of pad10*1 merges with D when D is the last byte.
                        blk_d[7] = 1'b1;
                        state_d  = FULL;
                        last_d   = 1'b1;
                        idx_d    = '0;
                    end else if (idx_q == IDX_W'(WORDS - 1)) begin
                        state_d = FULL;
                        last_d  = 1'b0;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            FULL: begin
                if (bus.f_ack) begin
                    blk_d   = '0;
                    last_d  = 1'b0;
                    state_d = ABSORB;
                end
            end
            default: state_d = ABSORB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ABSORB;
            idx_q   <= '0;
            blk_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            blk_q   <= blk_d;
            last_q  <= last_d;
        end
    end

    assign bus.out         = blk_q;
    assign bus.out_ready   = (state_q == FULL);
    assign bus.buffer_full = (state_q == FULL);
    assign bus.out_last    = last_q;

endmodule
